apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles with PREADY low before abort; legal range 2..255.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have PCLK  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have PRESET  input  1  synchronous active-high reset.
REQ-007 SHALL have cmd_valid  input  1  request present.
REQ-008 SHALL have cmd_ready  output  1  request accepted when high together with cmd_valid.
REQ-009 SHALL have cmd_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-011 SHALL have cmd_wdata  input  DATA_WIDTH  write data.
REQ-012 SHALL have rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have rsp_rdata  output  DATA_WIDTH  read data.
REQ-014 SHALL have rsp_timeout  output  1  transfer aborted by timeout.
REQ-015 SHALL have PADDR  output  ADDR_WIDTH  APB address.
REQ-016 SHALL have PSEL  output  1  APB select.
REQ-017 SHALL have PENABLE  output  1  APB enable.
REQ-018 SHALL have PWRITE  output  1  APB direction.
REQ-019 SHALL have PWDATA  output  DATA_WIDTH  APB write data.
REQ-020 SHALL have PRDATA  input  DATA_WIDTH  APB read data.
REQ-021 SHALL have PREADY  input  1  APB slave ready.

Function
REQ-022 SHALL implement an FSM with states IDLE, SETUP and ACCESS; all APB and rsp outputs registered.
REQ-023 SHALL drive cmd_ready = 1 only in IDLE (combinational from state); a command is captured on the edge where cmd_valid && cmd_ready.
REQ-024 SHALL, on capture, move IDLE->SETUP and load PADDR/PWRITE/PWDATA from the cmd_* inputs; SETUP drives PSEL=1, PENABLE=0.
REQ-025 SHALL move SETUP->ACCESS unconditionally after one cycle; ACCESS drives PSEL=1, PENABLE=1.
REQ-026 SHALL hold PADDR, PWRITE and PWDATA stable from SETUP through the end of ACCESS, and keep their last values in IDLE.
REQ-027 SHALL sample PREADY on each rising edge in ACCESS; if PREADY=1, move to IDLE, clear PSEL/PENABLE, and pulse rsp_valid=1 for one cycle with rsp_timeout=0.
REQ-028 SHALL, on a completed read, capture PRDATA into rsp_rdata on the PREADY edge; on a completed write, set rsp_rdata to 0.
REQ-029 SHALL count consecutive ACCESS cycles with PREADY=0 in a wait counter that clears on entry to SETUP.
REQ-030 SHALL abort when the wait counter reaches TIMEOUT: move to IDLE, clear PSEL/PENABLE, and pulse rsp_valid=1 with rsp_timeout=1 and rsp_rdata=0.
REQ-031 SHALL give PREADY=1 priority over timeout when both occur on the same edge (normal completion).
REQ-032 SHALL have minimum latency of 3 cycles: command accepted at edge T0, SETUP in cycle T0..T1, ACCESS in T1..T2, rsp_valid high in T2..T3 when PREADY=1 at T2.
REQ-033 SHALL accept a new command in the same cycle that rsp_valid is high (IDLE), giving back-to-back transfers with one IDLE cycle between them.
REQ-034 SHALL ignore cmd_valid outside IDLE; cmd_* inputs need not be held stable after acceptance.
REQ-035 SHALL drive rsp_valid=0 in every cycle other than the completion/abort pulse.

Reset
REQ-036 SHALL, when PRESET=1 on a rising edge, set state=IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0 and wait counter=0.
REQ-037 SHALL force cmd_ready=0 while PRESET=1.
REQ-038 SHALL, if reset is asserted mid-transfer (SETUP or ACCESS), abandon the transfer without producing rsp_valid.

Verification
REQ-039 Write: cmd addr=0x10, wdata=0xA5A5A5A5, PREADY tied 1 -> SETUP (PSEL=1, PENABLE=0) for 1 cycle, ACCESS for 1 cycle, rsp_valid pulse with rsp_rdata=0, rsp_timeout=0, 3 cycles total.
REQ-040 Read: write 0x12345678 to 0x20, then read 0x20 -> rsp_rdata=0x12345678, PWRITE=0 throughout the read.
REQ-041 Wait states: PREADY low for 3 ACCESS cycles, then high -> PSEL/PENABLE and PADDR stay stable for 4 ACCESS cycles; single rsp_valid pulse with rsp_timeout=0.
REQ-042 Timeout: TIMEOUT=16, PREADY held 0 -> exactly 16 ACCESS cycles, then rsp_valid=1, rsp_timeout=1, rsp_rdata=0, PSEL=0; the next command is accepted normally.
REQ-043 Back-to-back: cmd_valid held high with two queued commands -> second accepted in the cycle rsp_valid is high for the first; its SETUP follows one cycle later.
REQ-044 Reset mid-ACCESS: assert PRESET during ACCESS with PREADY=0 -> next edge PSEL=0, PENABLE=0, all outputs 0, no rsp_valid pulse.

Source files
------------

// File: rtl/apb_master.sv
// APB master: turns single-beat cmd_* requests into APB SETUP/ACCESS transfers
// and reports completion, read data, or a wait-state timeout on rsp_*.
module apb_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

   state_t     state_q;
   logic [7:0] wait_q;
   logic [7:0] wait_d;

   // wait_d is the number of PREADY-low ACCESS cycles including the current one
   assign wait_d    = wait_q + 8'd1;
   assign cmd_ready = (state_q == IDLE) && !PRESET;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PADDR       <= '0;
         PWRITE      <= 1'b0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  state_q <= SETUP;
                  wait_q  <= '0;
                  PSEL    <= 1'b1;
                  PENABLE <= 1'b0;
                  PADDR   <= cmd_addr;
                  PWRITE  <= cmd_write;
                  PWDATA  <= cmd_wdata;
               end
            end
            SETUP: begin
               state_q <= ACCESS;
               PENABLE <= 1'b1;
            end
            ACCESS: begin
               // A ready slave wins even on the edge the timeout would fire
               if (PREADY) begin
                  state_q   <= IDLE;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
               end else if (wait_d == WAIT_LIMIT) begin
                  state_q     <= IDLE;
                  wait_q      <= wait_d;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= '0;
               end else begin
                  wait_q <= wait_d;
               end
            end
            default: begin
               state_q <= IDLE;
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small memory-backed APB slave.
module tb_apb_master;

   logic        PCLK;
   logic        PRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_timeout;
   logic [7:0]  PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mem [256];

   apb_master #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(8),
      .TIMEOUT(16)
   ) dut (
      .PCLK(PCLK),
      .PRESET(PRESET),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_timeout(rsp_timeout),
      .PADDR(PADDR),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PWRITE(PWRITE),
      .PWDATA(PWDATA),
      .PRDATA(PRDATA),
      .PREADY(PREADY)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
   end
   assign PRDATA = mem[PADDR];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Presents one command for a single edge, then scrambles the cmd_* inputs.
   task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
      $display("txn %s addr=%h wdata=%h", w ? "WR" : "RD", a, d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
      cmd_write = ~w;
      cmd_addr  = 8'hEE;
      cmd_wdata = 32'hCAFEBABE;
   endtask

   task automatic wait_rsp(input int max, output int cyc);
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < max) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      logic [78:0] outs;
      PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 8'h11; cmd_wdata = 32'h22222222; PREADY = 1'b1;
      tick(); tick(); tick();
      n_cmp++;
      if (cmd_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
      end
      outs = {PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_timeout};
      n_cmp++;
      if (outs !== '0) begin
         n_err++; $display("FAIL reset_outputs: got %h want 0", outs);
      end
      cmd_valid = 1'b0;
      PRESET = 1'b0;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_write();
      PREADY = 1'b1;
      issue(1'b1, 8'h10, 32'hA5A5A5A5);
      n_cmp++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid} !== {3'b101, 8'h10, 32'hA5A5A5A5, 2'b00}) begin
         n_err++; $display("FAIL write_setup: got psel=%b pen=%b pw=%b a=%h d=%h rdy=%b rv=%b want 1 0 1 10 a5a5a5a5 0 0",
                           PSEL, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid);
      end
      tick();
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, PADDR, PWDATA} !== {3'b110, 8'h10, 32'hA5A5A5A5}) begin
         n_err++; $display("FAIL write_access: got psel=%b pen=%b rv=%b a=%h d=%h want 1 1 0 10 a5a5a5a5",
                           PSEL, PENABLE, rsp_valid, PADDR, PWDATA);
      end
      tick();
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, rsp_timeout, rsp_rdata, cmd_ready, PADDR} !== {4'b0010, 32'h0, 1'b1, 8'h10}) begin
         n_err++; $display("FAIL write_done: got psel=%b pen=%b rv=%b to=%b rd=%h rdy=%b a=%h want 0 0 1 0 0 1 10",
                           PSEL, PENABLE, rsp_valid, rsp_timeout, rsp_rdata, cmd_ready, PADDR);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL write_pulse_end: got %b want 0", rsp_valid);
      end
   endtask

   task automatic test_read();
      int cyc;
      PREADY = 1'b1;
      issue(1'b1, 8'h20, 32'h12345678);
      wait_rsp(10, cyc);
      tick();
      issue(1'b0, 8'h20, 32'h0);
      n_cmp++;
      if ({PWRITE, PADDR} !== {1'b0, 8'h20}) begin
         n_err++; $display("FAIL read_setup: got pw=%b a=%h want 0 20", PWRITE, PADDR);
      end
      tick();
      n_cmp++;
      if ({PWRITE, PENABLE} !== 2'b01) begin
         n_err++; $display("FAIL read_access: got pw=%b pen=%b want 0 1", PWRITE, PENABLE);
      end
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_timeout, PWRITE, rsp_rdata} !== {3'b100, 32'h12345678}) begin
         n_err++; $display("FAIL read_data: got rv=%b to=%b pw=%b rd=%h want 1 0 0 12345678",
                           rsp_valid, rsp_timeout, PWRITE, rsp_rdata);
      end
      tick();
      issue(1'b1, 8'h30, 32'hDEADBEEF);
      wait_rsp(10, cyc);
      n_cmp++;
      if ({rsp_valid, cyc, rsp_rdata} !== {1'b1, 32'd2, 32'h0}) begin
         n_err++; $display("FAIL write_clears_rdata: got rv=%b cyc=%0d rd=%h want 1 2 0", rsp_valid, cyc, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_wait_states();
      PREADY = 1'b0;
      issue(1'b0, 8'h20, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({PSEL, PENABLE, rsp_valid, PADDR} !== {3'b110, 8'h20}) begin
            n_err++; $display("FAIL wait_cycle%0d: got psel=%b pen=%b rv=%b a=%h want 1 1 0 20",
                              i, PSEL, PENABLE, rsp_valid, PADDR);
         end
         if (i == 3) PREADY = 1'b1;
      end
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_timeout, PSEL, rsp_rdata} !== {3'b100, 32'h12345678}) begin
         n_err++; $display("FAIL wait_done: got rv=%b to=%b psel=%b rd=%h want 1 0 0 12345678",
                           rsp_valid, rsp_timeout, PSEL, rsp_rdata);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL wait_single_pulse: got %b want 0", rsp_valid);
      end
   endtask

   task automatic test_timeout();
      int n;
      int cyc;
      PREADY = 1'b0;
      issue(1'b0, 8'h20, 32'h0);
      n = 0;
      tick();
      while (PSEL && PENABLE && n < 40) begin
         n++;
         tick();
      end
      n_cmp++;
      if (n !== 16) begin
         n_err++; $display("FAIL timeout_access_cycles: got %0d want 16", n);
      end
      n_cmp++;
      if ({rsp_valid, rsp_timeout, PSEL, PENABLE, rsp_rdata} !== {4'b1100, 32'h0}) begin
         n_err++; $display("FAIL timeout_rsp: got rv=%b to=%b psel=%b pen=%b rd=%h want 1 1 0 0 0",
                           rsp_valid, rsp_timeout, PSEL, PENABLE, rsp_rdata);
      end
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_timeout, cmd_ready} !== 3'b001) begin
         n_err++; $display("FAIL timeout_after: got rv=%b to=%b rdy=%b want 0 0 1", rsp_valid, rsp_timeout, cmd_ready);
      end
      PREADY = 1'b1;
      issue(1'b1, 8'h50, 32'h000055AA);
      n_cmp++;
      if ({PSEL, PENABLE, PADDR} !== {2'b10, 8'h50}) begin
         n_err++; $display("FAIL timeout_next_setup: got psel=%b pen=%b a=%h want 1 0 50", PSEL, PENABLE, PADDR);
      end
      wait_rsp(10, cyc);
      n_cmp++;
      if ({rsp_valid, rsp_timeout, cyc} !== {2'b10, 32'd2}) begin
         n_err++; $display("FAIL timeout_next_done: got rv=%b to=%b cyc=%0d want 1 0 2", rsp_valid, rsp_timeout, cyc);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      PREADY = 1'b1;
      $display("txn WR addr=60 wdata=11111111 (held valid)");
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h60; cmd_wdata = 32'h11111111;
      tick();
      $display("txn RD addr=60 (queued)");
      cmd_write = 1'b0; cmd_wdata = 32'h99999999;
      tick();
      n_cmp++;
      if ({PSEL, PENABLE, PWRITE, PWDATA} !== {3'b111, 32'h11111111}) begin
         n_err++; $display("FAIL b2b_ignore_cmd: got psel=%b pen=%b pw=%b d=%h want 1 1 1 11111111",
                           PSEL, PENABLE, PWRITE, PWDATA);
      end
      tick();
      n_cmp++;
      if ({rsp_valid, cmd_ready, PSEL} !== 3'b110) begin
         n_err++; $display("FAIL b2b_first_done: got rv=%b rdy=%b psel=%b want 1 1 0", rsp_valid, cmd_ready, PSEL);
      end
      tick();
      cmd_valid = 1'b0;
      n_cmp++;
      if ({rsp_valid, PSEL, PENABLE, PWRITE, PADDR} !== {4'b0100, 8'h60}) begin
         n_err++; $display("FAIL b2b_second_setup: got rv=%b psel=%b pen=%b pw=%b a=%h want 0 1 0 0 60",
                           rsp_valid, PSEL, PENABLE, PWRITE, PADDR);
      end
      tick();
      tick();
      n_cmp++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h11111111}) begin
         n_err++; $display("FAIL b2b_second_done: got rv=%b rd=%h want 1 11111111", rsp_valid, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid_access();
      logic [78:0] outs;
      int cyc;
      int pulses;
      PREADY = 1'b0;
      issue(1'b1, 8'h70, 32'hFFFFFFFF);
      tick();
      tick();
      PRESET = 1'b1;
      tick();
      outs = {PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_timeout};
      n_cmp++;
      if (outs !== '0) begin
         n_err++; $display("FAIL reset_mid_outputs: got %h want 0", outs);
      end
      PRESET = 1'b0;
      PREADY = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid === 1'b1 || PSEL === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_err++; $display("FAIL reset_mid_no_rsp: got %0d active cycles want 0", pulses);
      end
      issue(1'b0, 8'h20, 32'h0);
      wait_rsp(10, cyc);
      n_cmp++;
      if ({rsp_valid, cyc, rsp_rdata} !== {1'b1, 32'd2, 32'h12345678}) begin
         n_err++; $display("FAIL reset_mid_recover: got rv=%b cyc=%0d rd=%h want 1 2 12345678",
                           rsp_valid, cyc, rsp_rdata);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wait_states();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
